// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO pointer/flag controller.
package fifo_pkg;

    // Default address width; the FIFO holds 2**ADDR_W entries.
    localparam int DEF_ADDR_W = 3;

    // Number of entries for a given address width.
    function automatic int depth_of(input int addr_w);
        return 2 ** addr_w;
    endfunction

    // Fill level needs one extra bit so that DEPTH itself is representable.
    function automatic int level_w(input int addr_w);
        return addr_w + 1;
    endfunction

    // Registered status flags, kept together so they update as one unit.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

endpackage : fifo_pkg

// File: rtl/counter.sv
// K-bit enable counter; wraps modulo 2**K naturally.
module counter #(
    parameter int K = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [K-1:0] o_count
);

    localparam logic [K-1:0] ONE = K'(1);

    logic [K-1:0] r_count;

    // Advance by one on each enabled cycle; async reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            // NOTE: state registers use <= so every flop samples pre-edge values.
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule : counter

// File: rtl/fifo_ctrl.sv
// Pointer, level, flag and sticky-error controller for a synchronous FIFO
// built around an external dual-port RAM with a 1-cycle read.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              clr_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int LVL_W = level_w(ADDR_W);
    localparam int DEPTH = depth_of(ADDR_W);

    localparam logic [LVL_W-1:0] ONE_L    = LVL_W'(1);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_TH);

    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] w_level_nxt;
    flags_t           r_flags;
    flags_t           w_flags_nxt;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    // Accept decisions use the flags registered before this edge.
    assign w_wr_en   = wr_req & ~r_flags.full;
    assign w_rd_en   = rd_req & ~r_flags.empty;
    assign w_ovf_evt = wr_req & r_flags.full;
    assign w_unf_evt = rd_req & r_flags.empty;

    counter #(.K(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_wr_en),
        .o_count (wr_addr)
    );

    counter #(.K(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_rd_en),
        .o_count (rd_addr)
    );

    // Next fill level and the flags derived from it.
    always_comb begin
        // NOTE: assign every always_comb output first so no path infers a latch.
        w_level_nxt = r_level;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_level_nxt = r_level + ONE_L;
            2'b01:   w_level_nxt = r_level - ONE_L;
            default: w_level_nxt = r_level;
        endcase
        w_flags_nxt.full         = (w_level_nxt == DEPTH_L);
        w_flags_nxt.empty        = (w_level_nxt == '0);
        w_flags_nxt.almost_full  = (w_level_nxt >= AFULL_L);
        w_flags_nxt.almost_empty = (w_level_nxt <= AEMPTY_L);
    end

    // Level, flags and read-valid pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level                <= '0;
            r_flags.full           <= 1'b0;
            r_flags.empty          <= 1'b1;
            r_flags.almost_full    <= 1'b0;
            r_flags.almost_empty   <= 1'b1;
            r_rd_valid             <= 1'b0;
        end else begin
            r_level    <= w_level_nxt;
            r_flags    <= w_flags_nxt;
            r_rd_valid <= w_rd_en;
        end
    end

    // Sticky errors: a new event outranks a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)    r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
            if (w_unf_evt)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    assign wr_en        = w_wr_en;
    assign rd_en        = w_rd_en;
    assign rd_valid     = r_rd_valid;
    assign level        = r_level;
    assign full         = r_flags.full;
    assign empty        = r_flags.empty;
    assign almost_full  = r_flags.almost_full;
    assign almost_empty = r_flags.almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_ctrl

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the team's synchronous FIFO. It sequences the write and read address counters and gates the external dual-port RAM strobes.
- It produces registered full, empty, almost-full and almost-empty flags, plus the fill level.
- It records sticky overflow and underflow errors and sits between the requester/consumer handshake and the storage array.

Parameters:
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- AFULL_TH, 6, almost_full asserts when level >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH (0..DEPTH-1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wr_req  input  1  producer requests a write this cycle.
- rd_req  input  1  consumer requests a read this cycle.
- clr_err  input  1  synchronous clear of the sticky error flags.
- wr_en  output  1  RAM write strobe, combinational: wr_req & ~full.
- rd_en  output  1  RAM read strobe, combinational: rd_req & ~empty.
- wr_addr  output  ADDR_W  RAM write address, registered.
- rd_addr  output  ADDR_W  RAM read address, registered.
- rd_valid  output  1  registered rd_en; RAM read data is valid this cycle.
- level  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  level == DEPTH, registered.
- empty  output  1  level == 0, registered.
- almost_full  output  1  level >= AFULL_TH, registered.
- almost_empty  output  1  level <= AEMPTY_TH, registered.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async, any time, including mid-transfer) sets the following, effective immediately without waiting for a clock edge:
  - wr_addr = rd_addr = 0, level = 0, rd_valid = 0.
  - empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (AFULL_TH >= 1).
  - overflow = underflow = 0.
- Accept rules:
  - A write is accepted iff wr_req & ~full; a read is accepted iff rd_req & ~empty.
  - Both are evaluated against the flag values registered before the edge.
- Pointers:
  - wr_addr increments by 1 on an accepted write; rd_addr increments by 1 on an accepted read.
  - Both wrap modulo DEPTH (DEPTH-1 -> 0) with no extra logic.
- Level update:
  - Write only: level + 1.
  - Read only: level - 1.
  - Both or neither: level unchanged.
  - level never leaves 0..DEPTH.
- Flags are recomputed from the next-state level, so they change on the same edge as level. Latency from an accepted request to the flag change is 1 cycle.
- Simultaneous events:
  - Full with wr_req & rd_req: the read is accepted, the write is rejected and overflow is set. Next cycle level = DEPTH-1 and full = 0.
  - Empty with wr_req & rd_req: the write is accepted, the read is rejected and underflow is set. Next cycle level = 1 and empty = 0.
  - Otherwise, with both requests accepted, both pointers advance and level holds.
- Errors:
  - overflow and underflow set on the edge following a rejected request and hold until clr_err or rst.
  - If clr_err coincides with a new error event, the set wins.
  - Rejected requests never move pointers or level.
- rd_valid is rd_en delayed by one cycle, matching the 1-cycle synchronous RAM read.

Decomposition:
- Shared package (fifo_pkg):
  - Default ADDR_W.
  - DEPTH derivation.
  - Level width constant ADDR_W+1.
- Sub-module: the existing K-bit enable counter (counter), instantiated twice with K = ADDR_W.
  - Write pointer: en = wr_en.
  - Read pointer: en = rd_en.
  - rst is shared with both instances.
- Level register, flag logic and error logic stay in fifo_ctrl.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, level=0, wr_addr=rd_addr=0, no strobes.
- Fill with 8 consecutive writes (ADDR_W=3) -> level 1..8 with flags as follows:
  - almost_empty drops after write 2.
  - almost_full rises at level 6.
  - full=1 after write 8.
  - wr_addr wraps 7->0.
  - A 9th write gives wr_en=0 and overflow=1 next cycle; level stays 8.
- From full, assert wr_req & rd_req together -> rd_en=1, wr_en=0, overflow=1; next cycle level=7 and full=0.
- From empty, read attempt -> rd_en=0, underflow=1, level=0; then clr_err -> underflow=0 next cycle.
- At level 4, 10 cycles of simultaneous wr_req & rd_req -> level stays 4 and both pointers advance by 10 mod 8 = 2. rd_valid follows rd_en by 1 cycle.
- rst asserted mid-burst between clock edges -> all outputs reach reset values without waiting for a clock edge; the first write after release goes to wr_addr 0.
